// File: rtl/uart_mmio_if.sv
// Data-RAM port bundle between mem_stage (master) and the console device (slave).
interface uart_mmio_if;
  logic [63:0] ram_addr;
  logic        ram_r_ena;
  logic        ram_w_ena;
  logic [63:0] ram_w_mask;
  logic [63:0] ram_w_data;
  logic [63:0] ram_r_data;

  modport master (
    output ram_addr, ram_r_ena, ram_w_ena, ram_w_mask, ram_w_data,
    input  ram_r_data
  );

  modport slave (
    input  ram_addr, ram_r_ena, ram_w_ena, ram_w_mask, ram_w_data,
    output ram_r_data
  );
endinterface

// File: rtl/uart_mmio.sv
// Memory-mapped console: paced TX byte FIFO toward the host, polled one-byte RX holding register.
// Optional UART_LOOPBACK_EN feeds popped TX bytes into the RX holding register instead of polling.
module uart_mmio #(
  parameter logic [63:0] BASE_ADDR  = 64'h0000_0000_1000_0000,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned TX_GAP     = 0,
  parameter int unsigned POLL_GAP   = 3
) (
  input  logic        clock,
  input  logic        reset,
  uart_mmio_if.slave  bus,
  output logic        io_uart_out_valid,
  output logic [7:0]  io_uart_out_ch,
  output logic        io_uart_in_valid,
  input  logic [7:0]  io_uart_in_ch
);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned GW = $clog2(TX_GAP + 2);
  localparam int unsigned PW = $clog2(POLL_GAP + 2);

  typedef enum logic [1:0] {RX_IDLE, RX_POLL, RX_HOLD} rx_state_t;

  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [GW-1:0] gap_cnt;
  logic          out_valid_q;
  logic [7:0]    out_ch_q;
  logic          tx_err;

  rx_state_t     rx_state;
  logic [PW-1:0] poll_cnt;
  logic          in_valid_q;
  logic          rx_dr;
  logic [7:0]    rx_byte;

  logic       sel_c, rd_c, push_req_c, push_c, pop_c;
  logic [7:0] lsr_c;
  logic       unused_bits;

  assign sel_c      = (bus.ram_addr[63:3] == BASE_ADDR[63:3]);
  assign rd_c       = sel_c & bus.ram_r_ena;
  assign push_req_c = sel_c & bus.ram_w_ena & (bus.ram_w_mask[7:0] == 8'hFF);
  assign pop_c      = (count != '0) && (gap_cnt == '0);
  // A full FIFO still takes the byte when the head leaves on the same edge.
  assign push_c     = push_req_c & ((count < CW'(FIFO_DEPTH)) | pop_c);

  assign lsr_c = {tx_err, (count == '0) & ~out_valid_q, (count < CW'(FIFO_DEPTH)), 4'b0000, rx_dr};
  assign bus.ram_r_data = rd_c ? {16'h0000, lsr_c, 32'h0000_0000, (rx_dr ? rx_byte : 8'h00)} : '0;

  assign io_uart_out_valid = out_valid_q;
  assign io_uart_out_ch    = out_ch_q;
  assign io_uart_in_valid  = in_valid_q;

`ifdef UART_LOOPBACK_EN
  assign unused_bits = ^{bus.ram_addr[2:0], bus.ram_w_mask[63:8], bus.ram_w_data[63:8], poll_cnt, io_uart_in_ch};
`else
  assign unused_bits = ^{bus.ram_addr[2:0], bus.ram_w_mask[63:8], bus.ram_w_data[63:8]};
`endif

  always_ff @(posedge clock) begin
    if (push_c) fifo_mem[wr_ptr] <= bus.ram_w_data[7:0];
  end

  // TX pointers, pacing and drop flag; a drop on the same edge as an LSR read keeps the flag set.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      gap_cnt     <= '0;
      out_valid_q <= 1'b0;
      out_ch_q    <= 8'h00;
      tx_err      <= 1'b0;
    end else begin
      if (push_c) wr_ptr <= wr_ptr + AW'(1);
      if (pop_c) begin
        out_valid_q <= 1'b1;
        out_ch_q    <= fifo_mem[rd_ptr];
        rd_ptr      <= rd_ptr + AW'(1);
        gap_cnt     <= GW'(TX_GAP);
      end else begin
        out_valid_q <= 1'b0;
        if (gap_cnt != '0) gap_cnt <= gap_cnt - GW'(1);
      end
      count <= count + CW'(push_c) - CW'(pop_c);
      if (push_req_c & ~push_c) tx_err <= 1'b1;
      else if (rd_c)            tx_err <= 1'b0;
    end
  end

  // RX holding register; IDLE lasts POLL_GAP cycles before each poll.
  always_ff @(posedge clock) begin
    if (reset) begin
      rx_state   <= RX_IDLE;
      poll_cnt   <= PW'(POLL_GAP);
      in_valid_q <= 1'b0;
      rx_dr      <= 1'b0;
      rx_byte    <= 8'h00;
    end else begin
      in_valid_q <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
`ifdef UART_LOOPBACK_EN
          if (pop_c) begin
            rx_byte  <= fifo_mem[rd_ptr];
            rx_dr    <= 1'b1;
            rx_state <= RX_HOLD;
          end
`else
          if (poll_cnt <= PW'(1)) begin
            rx_state   <= RX_POLL;
            in_valid_q <= 1'b1;
          end else begin
            poll_cnt <= poll_cnt - PW'(1);
          end
`endif
        end
        RX_POLL: begin
          if (io_uart_in_ch != 8'hFF) begin
            rx_byte  <= io_uart_in_ch;
            rx_dr    <= 1'b1;
            rx_state <= RX_HOLD;
          end else if (POLL_GAP == 0) begin
            in_valid_q <= 1'b1;
          end else begin
            rx_state <= RX_IDLE;
            poll_cnt <= PW'(POLL_GAP);
          end
        end
        RX_HOLD: begin
          if (rd_c) begin
            rx_dr    <= 1'b0;
            rx_state <= RX_IDLE;
            poll_cnt <= PW'(POLL_GAP);
          end
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end
endmodule
